// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run controller slice.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } run_state_t;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 4096;

  // The host may own the memory port only while the core is parked.
  function automatic logic host_owns(run_state_t s);
    return (s == IDLE) || (s == FINISH);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Bundle of host, core and data-memory signals around the run controller.
// Wires only; no latency.
// host_gnt is the only host-side backpressure: no grant means retry next cycle.
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  // run control
  logic             go;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  // host memory access
  logic             host_req;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [DW-1:0]    host_wdata;
  logic             host_gnt;
  logic [DW-1:0]    host_rdata;

  // core side
  logic             core_start;
  logic             core_en;
  logic             core_done;
  logic             core_mem_read;
  logic             core_mem_write;
  logic [AW-1:0]    core_addr;
  logic [DW-1:0]    core_wdata;

  // data memory port
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_we;
  logic [DW-1:0]    mem_rdata;

  // the run controller side
  modport slave (
    input  go, host_req, host_we, host_addr, host_wdata,
           core_done, core_mem_read, core_mem_write, core_addr, core_wdata,
           mem_rdata,
    output busy, done, timeout, cycle_cnt, host_gnt, host_rdata,
           core_start, core_en, mem_addr, mem_wdata, mem_we
  );

  // the environment side (host, core, memory)
  modport master (
    output go, host_req, host_we, host_addr, host_wdata,
           core_done, core_mem_read, core_mem_write, core_addr, core_wdata,
           mem_rdata,
    input  busy, done, timeout, cycle_cnt, host_gnt, host_rdata,
           core_start, core_en, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/run_watchdog.sv
// Run-length watchdog: flags the RUN cycle in which the counter hits TIMEOUT-1.
// Combinational, zero latency; built only when RUN_WATCHDOG_EN is defined.
// No flow control; the controller decides what expiry means.
`ifdef RUN_WATCHDOG_EN
module run_watchdog #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  // expiry is only meaningful while the core is actually running
  assign expire = run && (cnt == LIMIT);

endmodule
`endif

// File: rtl/run_ctrl.sv
// Run sequencer (IDLE/START/RUN/FINISH) and host/core arbiter for the data memory.
// Control outputs registered off the FSM; mem mux and host_gnt combinational; host_rdata 1 cycle.
// Host is stalled (host_gnt=0) in START/RUN or when go is raised; go is dropped outside IDLE/FINISH.
// Optional watchdog: define RUN_WATCHDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic   clk,
  input  logic   reset_n,
  run_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  run_state_t       state;
  logic             start_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    rdata_q;
  logic             timeout_q;
  logic             expire;
  logic             host_phase;
  logic             host_gnt_c;

  assign host_phase = host_owns(state);
  // go takes priority over a same-cycle host request; nothing is granted under reset
  assign host_gnt_c = reset_n & host_phase & bus.host_req & ~bus.go;

  // sequencer with its registered control outputs and the run cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (bus.go) begin
            state   <= START;
            start_q <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt     <= '0;
          end
        end
        START: begin
          state   <= RUN;
          start_q <= 1'b0;
          en_q    <= 1'b1;
        end
        RUN: begin
          if (cnt != '1) cnt <= cnt + CNT_ONE;
          if (bus.core_done || expire) begin
            state  <= FINISH;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          start_q <= 1'b0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_WATCHDOG_EN
  run_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .run    (state == RUN),
    .cnt    (cnt),
    .expire (expire)
  );

  // sticky timeout flag: cleared when a new run is launched, set only if core_done lost the race
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (host_phase && bus.go) begin
      timeout_q <= 1'b0;
    end else if (expire && !bus.core_done) begin
      timeout_q <= 1'b1;
    end
  end
`else
  logic timeout_param_unused;
  assign timeout_param_unused = (TIMEOUT != 0);
  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  // data-memory port mux: host while parked, core while running, quiet in START and reset
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (reset_n) begin
      if (host_phase) begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_we    = host_gnt_c & bus.host_we;
      end else begin
        bus.mem_addr  = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
        bus.mem_we    = (state == RUN) & bus.core_mem_write & en_q;
      end
    end
  end

  // host read data is captured at the end of a granted read and held otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (host_gnt_c && !bus.host_we) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.host_gnt   = host_gnt_c;
  assign bus.host_rdata = rdata_q;
  assign bus.core_start = start_q;
  assign bus.core_en    = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cycle_cnt  = cnt;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized host/run mix.
// Behavioural memory model and run-length model kept in the bench.
// Watchdog scenario included when RUN_WATCHDOG_EN is defined.
module tb_run_ctrl;

`ifdef RUN_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  localparam int WD_LIMIT = 8;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [7:0] ram     [256];
  logic [7:0] exp_mem [256];

  run_ctrl_if #(.AW(8), .DW(8), .CNT_W(16)) bus ();

  run_ctrl #(.AW(8), .DW(8), .CNT_W(16), .TIMEOUT(WD_LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the data memory the controller fronts: combinational read, clocked write
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.go = 0; bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    bus.core_done = 0; bus.core_mem_read = 0; bus.core_mem_write = 0;
    bus.core_addr = 0; bus.core_wdata = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset_n = 0;
    step();
    step();
    #2 reset_n = 1;
    step();
  endtask

  // pulse go from IDLE/FINISH; returns during the first RUN cycle
  task automatic begin_run();
    bus.go = 1;
    step();
    bus.go = 0;
    step();
  endtask

  task automatic test_reset();
    quiet_inputs();
    bus.host_req = 1;
    reset_n = 0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.core_start, bus.core_en, bus.mem_we, bus.timeout, bus.host_gnt} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {bus.busy, bus.done, bus.core_start, bus.core_en, bus.mem_we, bus.timeout, bus.host_gnt});
    end
    total++;
    if (bus.cycle_cnt !== 16'd0 || bus.host_rdata !== 8'd0) begin
      bad++;
      $display("FAIL reset_values cnt=%0d rdata=%h exp cnt=0 rdata=00", bus.cycle_cnt, bus.host_rdata);
    end
    do_reset();
  endtask

  task automatic test_preload();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h10; bus.host_wdata = 8'h5A;
    #1;
    total++;
    if (bus.host_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h10) begin
      bad++;
      $display("FAIL preload_write gnt=%b we=%b addr=%h exp 1 1 10", bus.host_gnt, bus.mem_we, bus.mem_addr);
    end
    step();
    exp_mem[8'h10] = 8'h5A;
    bus.host_we = 0;
    #1;
    total++;
    if (bus.host_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL preload_read_gnt gnt=%b we=%b exp 1 0", bus.host_gnt, bus.mem_we);
    end
    step();
    bus.host_req = 0;
    total++;
    if (bus.host_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL preload_rdata got=%h exp=5a", bus.host_rdata);
    end
  endtask

  task automatic test_run();
    int starts;
    starts = 0;
    bus.go = 1;
    step();
    bus.go = 0;
    total++;
    if (bus.core_start !== 1'b1 || bus.busy !== 1'b1 || bus.core_en !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL run_start start=%b busy=%b en=%b to=%b exp 1 1 0 0",
               bus.core_start, bus.busy, bus.core_en, bus.timeout);
    end
    step();
    total++;
    if (bus.core_start !== 1'b0 || bus.core_en !== 1'b1 || bus.cycle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL run_first start=%b en=%b cnt=%0d exp 0 1 0", bus.core_start, bus.core_en, bus.cycle_cnt);
    end
    for (int i = 1; i <= 20; i++) begin
      bus.core_done = (i == 20);
      if (bus.core_start) starts++;
      step();
    end
    bus.core_done = 0;
    total++;
    if (bus.done !== 1'b1 || bus.cycle_cnt !== 16'd20 || bus.core_en !== 1'b0 || bus.busy !== 1'b0 || starts != 0) begin
      bad++;
      $display("FAIL run_finish done=%b cnt=%0d en=%b busy=%b extra_starts=%0d exp 1 20 0 0 0",
               bus.done, bus.cycle_cnt, bus.core_en, bus.busy, starts);
    end
  endtask

  task automatic test_contention();
    begin_run();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h33; bus.host_wdata = 8'h11;
    bus.core_addr = 8'h44; bus.core_wdata = 8'h99; bus.core_mem_write = 1;
    #1;
    total++;
    if (bus.host_gnt !== 1'b0 || bus.mem_addr !== 8'h44 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h99) begin
      bad++;
      $display("FAIL contention gnt=%b addr=%h we=%b wdata=%h exp 0 44 1 99",
               bus.host_gnt, bus.mem_addr, bus.mem_we, bus.mem_wdata);
    end
    step();
    exp_mem[8'h44] = 8'h99;
    bus.core_mem_write = 0; bus.host_req = 0; bus.host_we = 0;
    bus.core_done = 1;
    step();
    bus.core_done = 0;
    bus.host_req = 1; bus.host_addr = 8'h44;
    step();
    bus.host_addr = 8'h33;
    #1;
    total++;
    if (bus.host_rdata !== exp_mem[8'h44]) begin
      bad++;
      $display("FAIL contention_core_data got=%h exp=%h", bus.host_rdata, exp_mem[8'h44]);
    end
    step();
    bus.host_req = 0;
    total++;
    if (bus.host_rdata !== exp_mem[8'h33]) begin
      bad++;
      $display("FAIL contention_host_blocked got=%h exp=%h", bus.host_rdata, exp_mem[8'h33]);
    end
  endtask

  task automatic test_go_host();
    int odd;
    odd = 0;
    do_reset();
    bus.go = 1; bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h20; bus.host_wdata = 8'hEE;
    #1;
    total++;
    if (bus.host_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL go_wins gnt=%b we=%b exp 0 0", bus.host_gnt, bus.mem_we);
    end
    step();
    bus.go = 0; bus.host_req = 0; bus.host_we = 0;
    total++;
    if (bus.core_start !== 1'b1) begin
      bad++;
      $display("FAIL go_wins_start got=%b exp=1", bus.core_start);
    end
    step();
    for (int i = 1; i <= 6; i++) begin
      bus.go = (i <= 5);
      bus.core_done = (i == 6);
      #1;
      if (bus.core_start !== 1'b0 || bus.core_en !== 1'b1) odd++;
      step();
    end
    bus.go = 0; bus.core_done = 0;
    total++;
    if (odd != 0 || bus.cycle_cnt !== 16'd6 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL go_in_run bad_cycles=%0d cnt=%0d done=%b exp 0 6 1", odd, bus.cycle_cnt, bus.done);
    end
    step();
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL go_not_queued done=%b busy=%b exp 1 0", bus.done, bus.busy);
    end
    bus.host_req = 1; bus.host_addr = 8'h20;
    step();
    bus.host_req = 0;
    total++;
    if (bus.host_rdata !== exp_mem[8'h20]) begin
      bad++;
      $display("FAIL go_wins_no_write got=%h exp=%h", bus.host_rdata, exp_mem[8'h20]);
    end
  endtask

  task automatic test_async_reset();
    begin_run();
    repeat (5) step();
    #2;
    reset_n = 0;
    bus.core_mem_write = 1; bus.core_addr = 8'h55; bus.core_wdata = 8'h77;
    #1;
    total++;
    if (bus.core_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.cycle_cnt !== 16'd0 ||
        bus.busy !== 1'b0 || bus.host_rdata !== 8'd0) begin
      bad++;
      $display("FAIL async_reset en=%b we=%b cnt=%0d busy=%b rdata=%h exp 0 0 0 0 00",
               bus.core_en, bus.mem_we, bus.cycle_cnt, bus.busy, bus.host_rdata);
    end
    bus.core_mem_write = 0;
    step();
    #2 reset_n = 1;
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.core_start !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_idle busy=%b done=%b start=%b exp 0 0 0", bus.busy, bus.done, bus.core_start);
    end
  endtask

  task automatic test_watchdog();
    int n;
    n = 0;
    begin_run();
    while (!bus.done && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n != WD_LIMIT || bus.timeout !== 1'b1 || bus.cycle_cnt !== 16'(WD_LIMIT)) begin
      bad++;
      $display("FAIL watchdog_expire cycles=%0d to=%b cnt=%0d exp %0d 1 %0d",
               n, bus.timeout, bus.cycle_cnt, WD_LIMIT, WD_LIMIT);
    end
    step();
    total++;
    if (bus.timeout !== 1'b1) begin
      bad++;
      $display("FAIL watchdog_hold got=%b exp=1", bus.timeout);
    end
    bus.go = 1;
    step();
    bus.go = 0;
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL watchdog_clear got=%b exp=0", bus.timeout);
    end
    step();
    for (int i = 1; i <= WD_LIMIT; i++) begin
      bus.core_done = (i == WD_LIMIT);
      step();
    end
    bus.core_done = 0;
    total++;
    if (bus.timeout !== 1'b0 || bus.done !== 1'b1 || bus.cycle_cnt !== 16'(WD_LIMIT)) begin
      bad++;
      $display("FAIL watchdog_done_wins to=%b done=%b cnt=%0d exp 0 1 %0d",
               bus.timeout, bus.done, bus.cycle_cnt, WD_LIMIT);
    end
  endtask

  task automatic test_random();
    int         kind;
    int         len;
    int         eff;
    int         odd;
    logic       exp_to;
    logic [7:0] a;
    logic [7:0] d;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = a; bus.host_wdata = d;
        step();
        exp_mem[a] = d;
        bus.host_req = 0; bus.host_we = 0;
      end else if (kind == 1) begin
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = a;
        step();
        bus.host_req = 0;
        total++;
        if (bus.host_rdata !== exp_mem[a]) begin
          bad++;
          $display("FAIL rand_read addr=%h got=%h exp=%h", a, bus.host_rdata, exp_mem[a]);
        end
      end else begin
        len = $urandom_range(1, 12);
        exp_to = WD_ON && (len > WD_LIMIT);
        eff = exp_to ? WD_LIMIT : len;
        odd = 0;
        begin_run();
        for (int i = 1; i <= eff; i++) begin
          bus.core_done = (i == len);
          bus.core_mem_write = 1'($urandom);
          bus.core_addr = 8'($urandom);
          bus.core_wdata = 8'($urandom);
          bus.host_req = 1'($urandom);
          bus.host_we = 1;
          #1;
          if (bus.host_gnt !== 1'b0 || bus.mem_we !== bus.core_mem_write ||
              bus.mem_addr !== bus.core_addr) odd++;
          if (bus.core_mem_write) exp_mem[bus.core_addr] = bus.core_wdata;
          step();
        end
        quiet_inputs();
        total++;
        if (odd != 0 || bus.done !== 1'b1 || bus.cycle_cnt !== 16'(eff) || bus.timeout !== exp_to) begin
          bad++;
          $display("FAIL rand_run len=%0d bad_cycles=%0d done=%b cnt=%0d to=%b exp 0 1 %0d %b",
                   len, odd, bus.done, bus.cycle_cnt, bus.timeout, eff, exp_to);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    test_reset();
    test_preload();
    test_run();
    test_contention();
    test_go_host();
    test_async_reset();
`ifdef RUN_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit reached before summary");
    $fatal(1);
  end

endmodule
